load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/cpu_types_pkg.sv | 17 +
 rtl/load_store_unit_if.sv | 20 ++
 rtl/lsu_lane_picker.sv | 38 +++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the load/store unit: FSM state encoding and the
// word-alignment helper applied to outgoing memory addresses.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    DATA,
    DONE,
    HALT
  } lsu_state_t;

  function automatic logic [31:0] pad_word_addr(input logic [31:0] addr, input bit pad);
    return pad ? {addr[31:2], 2'b00} : addr;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory bus between the load/store unit (master) and the memory (slave).
// mem_ready may assert in the same cycle the request is raised.
interface load_store_unit_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_store;
  logic [31:0] mem_load;
  logic        mem_ready;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_store,
    input  mem_load, mem_ready
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_store,
    output mem_load, mem_ready
  );
endinterface

// File: rtl/lsu_lane_picker.sv
// Next-active-lane search for vector accesses.
// first=1: lowest eligible lane from index 0; first=0: lowest eligible lane above cur.
// Build option LSU_LANE_MASK_EN: honour mask; otherwise plain increment.
module lsu_lane_picker #(
  parameter  int unsigned THREADS = 4,
  localparam int unsigned LW      = $clog2(THREADS)
) (
  input  logic [LW-1:0]      cur,
  input  logic               first,
  input  logic [THREADS-1:0] mask,
  output logic [LW-1:0]      nxt,
  output logic               found
);

`ifdef LSU_LANE_MASK_EN
  // Priority search for the lowest set mask bit at or beyond the start point
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < THREADS; i++) begin
      if (!found && mask[i] && (first || i > 32'(cur))) begin
        nxt   = LW'(i);
        found = 1'b1;
      end
    end
  end
`else
  logic unused_mask;
  assign unused_mask = ^mask;

  // Every lane is active: step by one until the last lane
  always_comb begin
    nxt   = first ? '0 : cur + 1'b1;
    found = first || (cur != LW'(THREADS - 1));
  end
`endif

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: fetches an instruction, then performs an optional scalar
// or per-lane vector data access over a single-outstanding memory bus.
// Build option LSU_LANE_MASK_EN: skip vector lanes whose lane_mask bit is 0.
module load_store_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned THREADS  = 4,
  parameter bit          PAD_ADDR = 1'b1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [31:0]              iaddr,
  input  logic                     instReq,
  output logic [31:0]              iload,
  output logic                     iHit,
  input  logic                     readReq,
  input  logic                     writeReq,
  input  logic                     isVector,
  input  logic                     dhalt,
  input  logic [31:0]              sdaddr,
  input  logic [31:0]              sdstore,
  output logic [31:0]              sdload,
  input  logic [THREADS-1:0][31:0] vdaddr,
  input  logic [THREADS-1:0][31:0] vdstore,
  output logic [THREADS-1:0][31:0] vdload,
  input  logic [THREADS-1:0]       lane_mask,
  load_store_unit_if.master        mem
);

  localparam int unsigned LW = $clog2(THREADS);

  lsu_state_t         state, state_n;
  logic [LW-1:0]      lane_q, lane_n;
  logic               store_q, vec_q;
  logic [THREADS-1:0] pick_mask;
  logic [LW-1:0]      pick_nxt;
  logic               pick_found;
  logic               ren_c, wen_c;
  logic [31:0]        addr_c, store_c;

`ifdef LSU_LANE_MASK_EN
  logic [THREADS-1:0] mask_q;

  // Capture the lane mask once, when the vector access is entered
  always_ff @(posedge CLK) begin
    if (!nRST)               mask_q <= '0;
    else if (state == DECODE) mask_q <= lane_mask;
  end

  // DECODE searches the live mask for the first lane; DATA uses the captured copy
  assign pick_mask = (state == DECODE) ? lane_mask : mask_q;
`else
  assign pick_mask = lane_mask;
`endif

  lsu_lane_picker #(.THREADS(THREADS)) u_picker (
    .cur   (lane_q),
    .first (state == DECODE),
    .mask  (pick_mask),
    .nxt   (pick_nxt),
    .found (pick_found)
  );

  // State, lane counter and decoded operation registers
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= FETCH;
      lane_q  <= '0;
      store_q <= 1'b0;
      vec_q   <= 1'b0;
    end else begin
      state  <= state_n;
      lane_q <= lane_n;
      if (state == DECODE) begin
        store_q <= writeReq;
        vec_q   <= isVector;
      end
    end
  end

  // Next-state logic and bus request generation
  always_comb begin
    state_n = state;
    lane_n  = lane_q;
    ren_c   = 1'b0;
    wen_c   = 1'b0;
    addr_c  = '0;
    store_c = '0;
    iHit    = 1'b0;
    case (state)
      FETCH: begin
        if (dhalt) begin
          state_n = HALT;
        end else if (instReq) begin
          ren_c  = 1'b1;
          addr_c = iaddr;
          if (mem.mem_ready) state_n = DECODE;
        end
      end
      DECODE: begin
        if (writeReq || readReq) begin
          if (!isVector) begin
            state_n = DATA;
          end else if (pick_found) begin
            state_n = DATA;
            lane_n  = pick_nxt;
          end else begin
            state_n = DONE;
          end
        end else begin
          state_n = DONE;
        end
      end
      DATA: begin
        wen_c = store_q;
        ren_c = !store_q;
        if (vec_q) begin
          addr_c  = vdaddr[lane_q];
          store_c = store_q ? vdstore[lane_q] : '0;
        end else begin
          addr_c  = sdaddr;
          store_c = store_q ? sdstore : '0;
        end
        if (mem.mem_ready) begin
          if (vec_q && pick_found) begin
            lane_n = pick_nxt;
          end else begin
            state_n = DONE;
            lane_n  = '0;
          end
        end
      end
      DONE: begin
        iHit    = 1'b1;
        state_n = FETCH;
      end
      HALT: ;
      default: state_n = FETCH;
    endcase
  end

  // Requests are suppressed while reset is held so nothing is issued before the core restarts
  assign mem.mem_ren   = ren_c & nRST;
  assign mem.mem_wen   = wen_c & nRST;
  assign mem.mem_addr  = pad_word_addr(addr_c, PAD_ADDR);
  assign mem.mem_store = store_c;

  // Result registers, written only by a completed access
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      iload  <= '0;
      sdload <= '0;
      vdload <= '0;
    end else begin
      if (state == FETCH && ren_c && mem.mem_ready) iload <= mem.mem_load;
      if (state == DATA && !store_q && mem.mem_ready) begin
        if (vec_q) vdload[lane_q] <= mem.mem_load;
        else       sdload         <= mem.mem_load;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (THREADS=4, PAD_ADDR=1).
// Honours LSU_LANE_MASK_EN when the design is built with it.
module tb_load_store_unit;
  localparam int unsigned THREADS = 4;

  logic                     CLK = 1'b0;
  logic                     nRST;
  logic [31:0]              iaddr;
  logic                     instReq;
  logic [31:0]              iload;
  logic                     iHit;
  logic                     readReq, writeReq, isVector, dhalt;
  logic [31:0]              sdaddr, sdstore, sdload;
  logic [THREADS-1:0][31:0] vdaddr, vdstore, vdload;
  logic [THREADS-1:0]       lane_mask;

  int n_assert = 0;
  int n_fail   = 0;

  load_store_unit_if bus ();

  load_store_unit #(.THREADS(THREADS), .PAD_ADDR(1'b1)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iaddr     (iaddr),
    .instReq   (instReq),
    .iload     (iload),
    .iHit      (iHit),
    .readReq   (readReq),
    .writeReq  (writeReq),
    .isVector  (isVector),
    .dhalt     (dhalt),
    .sdaddr    (sdaddr),
    .sdstore   (sdstore),
    .sdload    (sdload),
    .vdaddr    (vdaddr),
    .vdstore   (vdstore),
    .vdload    (vdload),
    .lane_mask (lane_mask),
    .mem       (bus)
  );

  always #5 CLK = ~CLK;

  task automatic cyc;
    @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; iaddr = 32'h40; instReq = 1'b1; dhalt = 1'b0;
    readReq = 1'b0; writeReq = 1'b0; isVector = 1'b0;
    sdaddr = '0; sdstore = '0; vdaddr = '0; vdstore = '0; lane_mask = '1;
    bus.mem_ready = 1'b1; bus.mem_load = 32'h0000_0033;

    // Reset state
    cyc; cyc; #1;
    check("rst_ren", 32'(bus.mem_ren), 32'd0);
    check("rst_wen", 32'(bus.mem_wen), 32'd0);
    check("rst_ihit", 32'(iHit), 32'd0);
    check("rst_iload", iload, 32'd0);
    check("rst_sdload", sdload, 32'd0);
    for (int i = 0; i < 4; i++) check("rst_vdload", vdload[i], 32'd0);

    // Non-memory instruction: iHit every 3 cycles, mem_ren only in FETCH
    nRST = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      check("alu_ren", 32'(bus.mem_ren), 32'(k % 3 == 0));
      check("alu_wen", 32'(bus.mem_wen), 32'd0);
      check("alu_ihit", 32'(iHit), 32'(k % 3 == 2));
      if (k % 3 == 0) check("alu_addr", bus.mem_addr, 32'h40);
      cyc;
    end
    check("alu_iload", iload, 32'h0000_0033);

    // Scalar load at 0x100
    bus.mem_load = 32'h0000_A003; readReq = 1'b1; sdaddr = 32'h100; #1;
    check("lw_fetch_ren", 32'(bus.mem_ren), 32'd1);
    cyc; bus.mem_load = 32'hDEAD_BEEF; #1;
    check("lw_dec_ren", 32'(bus.mem_ren), 32'd0);
    check("lw_iload", iload, 32'h0000_A003);
    cyc; #1;
    check("lw_data_ren", 32'(bus.mem_ren), 32'd1);
    check("lw_data_wen", 32'(bus.mem_wen), 32'd0);
    check("lw_data_addr", bus.mem_addr, 32'h100);
    check("lw_data_ihit", 32'(iHit), 32'd0);
    cyc; #1;
    check("lw_done_ihit", 32'(iHit), 32'd1);
    check("lw_sdload", sdload, 32'hDEAD_BEEF);
    check("lw_done_ren", 32'(bus.mem_ren), 32'd0);
    readReq = 1'b0;
    cyc;

    // Scalar store with both requests high, misaligned address, one wait cycle
    bus.mem_load = 32'h0000_B023; readReq = 1'b1; writeReq = 1'b1;
    sdaddr = 32'h207; sdstore = 32'hCAFE_F00D;
    cyc; bus.mem_ready = 1'b0;
    cyc;
    for (int w = 0; w < 2; w++) begin
      bus.mem_ready = (w == 1); #1;
      check("sw_wen", 32'(bus.mem_wen), 32'd1);
      check("sw_ren", 32'(bus.mem_ren), 32'd0);
      check("sw_addr", bus.mem_addr, 32'h204);
      check("sw_store", bus.mem_store, 32'hCAFE_F00D);
      cyc;
    end
    #1;
    check("sw_ihit", 32'(iHit), 32'd1);
    check("sw_sdload_held", sdload, 32'hDEAD_BEEF);
    readReq = 1'b0; writeReq = 1'b0;
    cyc;

    // Vector store, every access completes two cycles late
    bus.mem_ready = 1'b1; bus.mem_load = 32'h0000_C027; writeReq = 1'b1; isVector = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vdaddr[i]  = 32'(4 * i);
      vdstore[i] = 32'h1000_0000 + 32'(i);
    end
    #1;
    check("vsw_fetch_ren", 32'(bus.mem_ren), 32'd1);
    cyc; bus.mem_ready = 1'b0; #1;
    check("vsw_dec_wen", 32'(bus.mem_wen), 32'd0);
    cyc;
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 3; w++) begin
        bus.mem_ready = (w == 2); #1;
        check("vsw_wen", 32'(bus.mem_wen), 32'd1);
        check("vsw_ren", 32'(bus.mem_ren), 32'd0);
        check("vsw_addr", bus.mem_addr, 32'(4 * i));
        check("vsw_store", bus.mem_store, 32'h1000_0000 + 32'(i));
        check("vsw_ihit", 32'(iHit), 32'd0);
        cyc;
      end
    end
    #1;
    check("vsw_done_ihit", 32'(iHit), 32'd1);
    check("vsw_done_wen", 32'(bus.mem_wen), 32'd0);
    writeReq = 1'b0; bus.mem_ready = 1'b1;
    cyc; #1;
    check("vsw_next_ihit", 32'(iHit), 32'd0);

    // Vector load, all lanes, zero-wait: 3+THREADS cycles
    bus.mem_load = 32'h0000_D007; readReq = 1'b1;
    for (int i = 0; i < 4; i++) vdaddr[i] = 32'h10 + 32'(4 * i);
    cyc; cyc;
    for (int i = 0; i < 4; i++) begin
      bus.mem_load = 32'hA0 + 32'(i); #1;
      check("vlw_ren", 32'(bus.mem_ren), 32'd1);
      check("vlw_addr", bus.mem_addr, 32'h10 + 32'(4 * i));
      cyc;
    end
    #1;
    check("vlw_ihit", 32'(iHit), 32'd1);
    for (int i = 0; i < 4; i++) check("vlw_vdload", vdload[i], 32'hA0 + 32'(i));
    cyc;

    // Vector load with lane_mask=0101
    bus.mem_load = 32'h0000_D007; lane_mask = 4'b0101;
    cyc; cyc;
    for (int i = 0; i < 4; i++) begin
`ifdef LSU_LANE_MASK_EN
      if (i == 1 || i == 3) continue;
`endif
      bus.mem_load = 32'hB0 + 32'(i); #1;
      check("vlm_ren", 32'(bus.mem_ren), 32'd1);
      check("vlm_addr", bus.mem_addr, 32'h10 + 32'(4 * i));
      cyc;
    end
    #1;
    check("vlm_ihit", 32'(iHit), 32'd1);
    check("vlm_vd0", vdload[0], 32'hB0);
    check("vlm_vd2", vdload[2], 32'hB2);
`ifdef LSU_LANE_MASK_EN
    check("vlm_vd1", vdload[1], 32'hA1);
    check("vlm_vd3", vdload[3], 32'hA3);
`else
    check("vlm_vd1", vdload[1], 32'hB1);
    check("vlm_vd3", vdload[3], 32'hB3);
`endif
    cyc;

`ifdef LSU_LANE_MASK_EN
    // All-zero mask: DECODE straight to DONE with no data access
    bus.mem_load = 32'h0000_D007; lane_mask = '0;
    cyc; #1;
    check("vz_dec_ren", 32'(bus.mem_ren), 32'd0);
    cyc; #1;
    check("vz_ihit", 32'(iHit), 32'd1);
    check("vz_ren", 32'(bus.mem_ren), 32'd0);
    check("vz_wen", 32'(bus.mem_wen), 32'd0);
    cyc;
`endif
    lane_mask = '1;

    // Reset during lane 2 of a vector load
    bus.mem_load = 32'h0000_D007;
    cyc; cyc;
    bus.mem_load = 32'hC0; cyc;
    bus.mem_load = 32'hC1; cyc;
    bus.mem_ready = 1'b0; #1;
    check("vrst_lane2_addr", bus.mem_addr, 32'h18);
    nRST = 1'b0;
    cyc; #1;
    check("vrst_ren", 32'(bus.mem_ren), 32'd0);
    check("vrst_wen", 32'(bus.mem_wen), 32'd0);
    check("vrst_ihit", 32'(iHit), 32'd0);
    check("vrst_iload", iload, 32'd0);
    check("vrst_sdload", sdload, 32'd0);
    for (int i = 0; i < 4; i++) check("vrst_vdload", vdload[i], 32'd0);
    nRST = 1'b1; iaddr = 32'h80; bus.mem_ready = 1'b1; readReq = 1'b0; isVector = 1'b0; #1;
    check("vrst_fetch_ren", 32'(bus.mem_ren), 32'd1);
    check("vrst_fetch_addr", bus.mem_addr, 32'h80);

    // dhalt in FETCH: no request now or ever again
    dhalt = 1'b1; #1;
    check("halt_ren_now", 32'(bus.mem_ren), 32'd0);
    cyc; dhalt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("halt_ren", 32'(bus.mem_ren), 32'd0);
      check("halt_wen", 32'(bus.mem_wen), 32'd0);
      check("halt_ihit", 32'(iHit), 32'd0);
      cyc;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
